imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the EXU immediate extractor: packs a 32-bit immediate into the
//  immediate bit positions of an RV32 instruction template, selected by extop.
//  Two-stage valid/ready pipeline used by the self-test instruction generator
//  and trace re-assembly. Flags immediates that the chosen format cannot
//  represent and counts them.
// PARAMETERS
//  CNT_W   16  width of saturating error counter err_cnt
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  extop      in   4      format: 0-4 I, 5 S, 6 B, 7 J, 8-9 U, 10-15 invalid
//  imm        in   32     immediate value (sign-extended form)
//  tmpl       in   32     instruction template; non-immediate bits kept as-is
//  out_valid  out  1      output beat valid
//  out_ready  in   1      downstream accepts when out_valid & out_ready
//  inst       out  32     assembled instruction
//  err        out  1      immediate not representable in selected format
//  err_cnt    out  CNT_W  count of delivered beats with err=1, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at edge): s1/s2 valid=0, out_valid=0, inst=0, err=0,
//   err_cnt=0. in_ready=0 while rst_n=0. Reset mid-stream drops all beats.
//  Pipeline: S1 registers extop/imm/tmpl and the range-check result; S2
//   registers assembled inst and err. Latency 2 cycles accept->out_valid.
//  Handshake: adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2;
//   in_ready = adv1 (combinational from out_ready, no skid). Full throughput
//   of 1 beat/cycle while out_ready=1. out_valid/inst/err held stable while
//   out_valid & ~out_ready. No beat lost, duplicated or reordered.
//  Encoding (bits not listed = tmpl bits):
//   I: inst[31:20]=imm[11:0]; ok iff imm[31:11] all equal
//   S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; ok iff imm[31:11] equal
//   B: inst[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11];
//      ok iff imm[0]=0 and imm[31:12] all equal
//   J: inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12];
//      ok iff imm[0]=0 and imm[31:20] all equal
//   U: inst[31:12]=imm[31:12]; ok iff imm[11:0]=0
//   invalid extop (10-15): inst=tmpl, err=1
//  err=~ok. Out-of-range beats still assembled from the truncated bits above.
//  err_cnt increments on out_valid & out_ready & err; holds at 2^CNT_W-1.
//  extop encodings 0-4 identical (I); 8 and 9 identical (U).
// TESTING
//  T1 extop=0 imm=0xFFFFF800 tmpl=0x00000013, out_ready=1 -> 2 cycles later
//     inst=0x80000013 err=0
//  T2 extop=6 imm=0x00000800 tmpl=0x00000063 -> inst=0x000000E3 err=0;
//     extop=8 imm=0x12345000 tmpl=0x00000037 -> inst=0x12345037 err=0
//  T3 extop=7 imm=0x00000001 tmpl=0x0000006F -> inst=0x0000006F err=1,
//     err_cnt=1 after handshake; extop=0xC -> inst=tmpl err=1, err_cnt=2
//  T4 out_ready=0 for 5 cycles, 4 beats offered back-to-back -> 2 accepted,
//     in_ready=0 from cycle 2, beat 1 held stable; release -> beats out in order
//  T5 back-to-back 100 random beats, out_ready random -> inst/err match
//     reference model, re-decoding inst with IMM gives imm whenever err=0
//  T6 rst_n=0 one cycle with both stages full -> out_valid=0, err_cnt=0 next
//     cycle; CNT_W=2 with 5 err beats -> err_cnt saturates at 3

Source files
------------

// File: rtl/imm_encoder_if.sv
// Beat-level bundle for imm_encoder: an input beat (extop/imm/tmpl) and the
// assembled output beat (inst/err), each with its own valid/ready pair.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  extop;
    logic [31:0] imm;
    logic [31:0] tmpl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        err;

    modport master (
        output in_valid, extop, imm, tmpl, out_ready,
        input  in_ready, out_valid, inst, err
    );

    modport slave (
        input  in_valid, extop, imm, tmpl, out_ready,
        output in_ready, out_valid, inst, err
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into the immediate field of an RV32
// instruction template through a two-stage valid/ready pipeline.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_J   = 3'd3,
        FMT_U   = 3'd4,
        FMT_BAD = 3'd5
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [3:0] op);
        fmt_e f;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: f = FMT_I;
            4'd5:                         f = FMT_S;
            4'd6:                         f = FMT_B;
            4'd7:                         f = FMT_J;
            4'd8, 4'd9:                   f = FMT_U;
            default:                      f = FMT_BAD;
        endcase
        return f;
    endfunction

    // Representable iff the bits dropped by the format are a pure sign extension
    // (and, for branch/jump offsets, the immediate is halfword aligned).
    function automatic logic range_ok(input fmt_e f, input logic [31:0] v);
        logic ok;
        case (f)
            FMT_I, FMT_S: ok = (&v[31:11]) | ~(|v[31:11]);
            FMT_B:        ok = ~v[0] & ((&v[31:12]) | ~(|v[31:12]));
            FMT_J:        ok = ~v[0] & ((&v[31:20]) | ~(|v[31:20]));
            FMT_U:        ok = ~(|v[11:0]);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode(input fmt_e f, input logic [31:0] v,
                                           input logic [31:0] t);
        logic [31:0] r;
        case (f)
            FMT_I:   r = {v[11:0], t[19:0]};
            FMT_S:   r = {v[11:5], t[24:12], v[4:0], t[6:0]};
            FMT_B:   r = {v[12], v[10:5], t[24:12], v[4:1], v[11], t[6:0]};
            FMT_J:   r = {v[20], v[10:1], v[11], v[19:12], t[11:0]};
            FMT_U:   r = {v[31:12], t[11:0]};
            default: r = t;
        endcase
        return r;
    endfunction

    logic              adv1_s;
    logic              adv2_s;
    logic              in_ok_s;
    logic [31:0]       enc_inst_s;

    logic              s1_valid_r;
    logic [3:0]        s1_extop_r;
    logic [31:0]       s1_imm_r;
    logic [31:0]       s1_tmpl_r;
    logic              s1_ok_r;

    logic              s2_valid_r;
    logic [31:0]       s2_inst_r;
    logic              s2_err_r;

    logic [CNT_W-1:0]  err_cnt_r;

    // Stage advance: a stage may load when empty or when the stage after it drains.
    always_comb begin
        adv2_s       = ~s2_valid_r | bus.out_ready;
        adv1_s       = ~s1_valid_r | adv2_s;
        bus.in_ready = adv1_s & rst_n;
    end

    // Range check on the incoming beat, registered alongside its data in S1.
    always_comb begin
        in_ok_s = range_ok(fmt_of(bus.extop), bus.imm);
    end

    // Instruction assembly from the S1 contents, registered into S2.
    always_comb begin
        enc_inst_s = encode(fmt_of(s1_extop_r), s1_imm_r, s1_tmpl_r);
    end

    // Stage 1 register: captures the accepted beat and its range-check result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_extop_r <= 4'h0;
            s1_imm_r   <= 32'h0;
            s1_tmpl_r  <= 32'h0;
            s1_ok_r    <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_extop_r <= bus.extop;
                s1_imm_r   <= bus.imm;
                s1_tmpl_r  <= bus.tmpl;
                s1_ok_r    <= in_ok_s;
            end
        end
    end

    // Stage 2 register: output beat, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_inst_r  <= 32'h0;
            s2_err_r   <= 1'b0;
        end else if (adv2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_inst_r <= enc_inst_s;
                s2_err_r  <= ~s1_ok_r;
            end
        end
    end

    // Saturating count of delivered beats flagged with err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (s2_valid_r && bus.out_ready && s2_err_r
                     && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + CNT_W'(1);
        end
    end

    assign bus.out_valid = s2_valid_r;
    assign bus.inst      = s2_inst_r;
    assign bus.err       = s2_err_r;
    assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed format cases, backpressure,
// randomized traffic against an arithmetic reference model, reset and saturation.
module tb_imm_encoder;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [31:0] imm;
        logic [3:0]  extop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;
    int          total = 0;
    int          bad = 0;
    int          model_cnt = 0;

    imm_encoder_if bus ();
    imm_encoder_if bus2 ();

    always #5 clk = ~clk;

    imm_encoder #(.CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    imm_encoder #(.CNT_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus2.slave),
        .err_cnt (err_cnt2)
    );

    // Reference: field placement by mask/shift, representability by signed range.
    function automatic exp_t ref_beat(input logic [3:0] op, input logic [31:0] im,
                                      input logic [31:0] tp);
        exp_t r;
        int   s;
        logic ok;
        logic even;
        s       = $signed(im);
        even    = ((im & 32'd1) == 32'd0);
        r.extop = op;
        r.imm   = im;
        if (op <= 4'd4) begin
            ok     = (s >= -2048) && (s <= 2047);
            r.inst = (tp & 32'h000FFFFF) | (im << 20);
        end else if (op == 4'd5) begin
            ok     = (s >= -2048) && (s <= 2047);
            r.inst = (tp & 32'h01FFF07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
        end else if (op == 4'd6) begin
            ok     = even && (s >= -4096) && (s <= 4095);
            r.inst = (tp & 32'h01FFF07F) | (((im >> 12) & 32'h1) << 31)
                   | (((im >> 5) & 32'h3F) << 25) | (((im >> 1) & 32'hF) << 8)
                   | (((im >> 11) & 32'h1) << 7);
        end else if (op == 4'd7) begin
            ok     = even && (s >= -1048576) && (s <= 1048575);
            r.inst = (tp & 32'h00000FFF) | (((im >> 20) & 32'h1) << 31)
                   | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                   | (((im >> 12) & 32'hFF) << 12);
        end else if (op <= 4'd9) begin
            ok     = ((im & 32'hFFF) == 32'd0);
            r.inst = (tp & 32'h00000FFF) | (im & 32'hFFFFF000);
        end else begin
            ok     = 1'b0;
            r.inst = tp;
        end
        r.err = !ok;
        return r;
    endfunction

    // Standard RV32 immediate extraction, used to round-trip representable beats.
    function automatic logic [31:0] ref_decode(input logic [31:0] i, input logic [3:0] op);
        logic [31:0] v;
        if (op <= 4'd4)      v = {{20{i[31]}}, i[31:20]};
        else if (op == 4'd5) v = {{20{i[31]}}, i[31:25], i[11:7]};
        else if (op == 4'd6) v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        else if (op == 4'd7) v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        else                 v = {i[31:12], 12'h000};
        return v;
    endfunction

    task automatic gen_beat(output logic [3:0] op, output logic [31:0] im, output logic [31:0] tp);
        op = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 4))
            0:       im = $urandom();
            1:       im = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       im = 32'($urandom_range(0, 2097151)) - 32'd1048576;
            3:       im = $urandom() & 32'hFFFFF000;
            default: im = 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
        if ($urandom_range(0, 1) == 1) im = im & 32'hFFFFFFFE;
        tp = $urandom();
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.extop      = 4'h0;
        bus.imm        = 32'h0;
        bus.tmpl       = 32'h0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
        bus2.extop     = 4'h0;
        bus2.imm       = 32'h0;
        bus2.tmpl      = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=00000000", bus.inst); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        total++; if (err_cnt2 !== 2'd0) begin bad++; $display("FAIL reset_err_cnt2 got=%0d want=0", err_cnt2); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        model_cnt     = 0;
        @(negedge clk);
    endtask

    task automatic test_formats();
        logic [3:0]  t_op   [5] = '{4'd0, 4'd6, 4'd8, 4'd7, 4'hC};
        logic [31:0] t_imm  [5] = '{32'hFFFFF800, 32'h00000800, 32'h12345000, 32'h00000001, 32'h00000000};
        logic [31:0] t_tmpl [5] = '{32'h00000013, 32'h00000063, 32'h00000037, 32'h0000006F, 32'h12345678};
        logic [31:0] t_inst [5] = '{32'h80000013, 32'h000000E3, 32'h12345037, 32'h0000006F, 32'h12345678};
        logic        t_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] t_cnt  [5] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.extop     = t_op[i];
            bus.imm       = t_imm[i];
            bus.tmpl      = t_tmpl[i];
            bus.out_ready = 1'b1;
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fmt%0d_in_ready got=%b want=1", i, bus.in_ready); end
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fmt%0d_latency got=%b want=0", i, bus.out_valid); end
            @(negedge clk);
            #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fmt%0d_out_valid got=%b want=1", i, bus.out_valid); end
            total++; if (bus.inst !== t_inst[i]) begin bad++; $display("FAIL fmt%0d_inst got=%h want=%h", i, bus.inst, t_inst[i]); end
            total++; if (bus.err !== t_err[i]) begin bad++; $display("FAIL fmt%0d_err got=%b want=%b", i, bus.err, t_err[i]); end
            if (t_err[i]) model_cnt++;
            @(negedge clk);
            #1;
            total++; if (err_cnt !== t_cnt[i]) begin bad++; $display("FAIL fmt%0d_err_cnt got=%0d want=%0d", i, err_cnt, t_cnt[i]); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fmt%0d_drain got=%b want=0", i, bus.out_valid); end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0]  b_op  [4] = '{4'd0, 4'd5, 4'd6, 4'd9};
        logic [31:0] b_imm [4];
        logic [31:0] b_tmpl[4];
        exp_t        q[$];
        exp_t        e;
        int          sent = 0;
        int          got = 0;
        for (int i = 0; i < 4; i++) begin
            b_imm[i]  = $urandom();
            b_tmpl[i] = $urandom();
        end
        for (int cyc = 0; cyc < 40 && !(sent == 4 && q.size() == 0); cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < 4);
            bus.extop     = b_op[sent % 4];
            bus.imm       = b_imm[sent % 4];
            bus.tmpl      = b_tmpl[sent % 4];
            bus.out_ready = (cyc >= 5);
            #1;
            if (cyc == 2) begin
                total++; if (sent != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", sent); end
            end
            if (cyc >= 2 && cyc < 5) begin
                total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, bus.in_ready); end
                total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", cyc, bus.out_valid); end
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=queued_beat", cyc, bus.inst); end
                else if (bus.inst !== q[0].inst) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, bus.inst, q[0].inst); end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL bp_extra got=%h want=none", bus.inst); end
                else begin
                    e = q.pop_front();
                    if (bus.inst !== e.inst || bus.err !== e.err) begin
                        bad++; $display("FAIL bp_order beat=%0d got=%h/%b want=%h/%b", got, bus.inst, bus.err, e.inst, e.err);
                    end
                    if (e.err) model_cnt++;
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_beat(bus.extop, bus.imm, bus.tmpl));
                sent++;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (got != 4) begin bad++; $display("FAIL bp_delivered got=%0d want=4", got); end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          sent = 0;
        int          got = 0;
        logic [3:0]  op;
        logic [31:0] im;
        logic [31:0] tp;
        logic        held = 1'b0;
        logic [31:0] h_inst = 32'h0;
        logic        h_err = 1'b0;
        gen_beat(op, im, tp);
        for (int cyc = 0; cyc < 3000 && !(sent == 100 && q.size() == 0); cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < 100) && ($urandom_range(0, 7) != 0);
            bus.extop     = op;
            bus.imm       = im;
            bus.tmpl      = tp;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (held) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.inst !== h_inst || bus.err !== h_err) begin
                    bad++; $display("FAIL rnd_stable got=%b/%h/%b want=1/%h/%b", bus.out_valid, bus.inst, bus.err, h_inst, h_err);
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            h_inst = bus.inst;
            h_err  = bus.err;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rnd_extra got=%h want=none", bus.inst); end
                else begin
                    e = q.pop_front();
                    if (bus.inst !== e.inst || bus.err !== e.err) begin
                        bad++; $display("FAIL rnd_beat n=%0d op=%0d imm=%h got=%h/%b want=%h/%b", got, e.extop, e.imm, bus.inst, bus.err, e.inst, e.err);
                    end
                    if (e.err) model_cnt++;
                    if (!e.err) begin
                        total++;
                        if (ref_decode(bus.inst, e.extop) !== e.imm) begin
                            bad++; $display("FAIL rnd_roundtrip op=%0d got=%h want=%h", e.extop, ref_decode(bus.inst, e.extop), e.imm);
                        end
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_beat(op, im, tp));
                sent++;
                gen_beat(op, im, tp);
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        total++; if (got != 100) begin bad++; $display("FAIL rnd_delivered got=%0d want=100", got); end
        total++; if (err_cnt !== 16'(model_cnt)) begin bad++; $display("FAIL rnd_err_cnt got=%0d want=%0d", err_cnt, model_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.extop     = 4'hF;
        bus.imm       = 32'h0;
        bus.tmpl      = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_full got=%b/%b want=1/0", bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL mid_err_cnt got=%0d want=0", err_cnt); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_dropped cyc=%0d got=%b want=0", i, bus.out_valid); end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        logic [31:0] tp;
        logic [1:0]  want;
        for (int n = 1; n <= 5; n++) begin
            tp = $urandom();
            @(negedge clk);
            bus2.in_valid  = 1'b1;
            bus2.extop     = 4'(10 + (n % 6));
            bus2.imm       = $urandom();
            bus2.tmpl      = tp;
            bus2.out_ready = 1'b1;
            @(negedge clk);
            bus2.in_valid = 1'b0;
            @(negedge clk);
            #1;
            total++; if (bus2.inst !== tp || bus2.err !== 1'b1) begin
                bad++; $display("FAIL sat_beat%0d got=%h/%b want=%h/1", n, bus2.inst, bus2.err, tp);
            end
            @(negedge clk);
            #1;
            want = (n >= 3) ? 2'd3 : 2'(n);
            total++; if (err_cnt2 !== want) begin bad++; $display("FAIL sat_cnt%0d got=%0d want=%0d", n, err_cnt2, want); end
        end
        bus2.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
